// File: rtl/ram_pkg.sv
// ram_pkg: shared read-during-write mode constants and init FSM state encoding
package ram_pkg;
  localparam bit RD_FIRST = 1'b0;
  localparam bit WR_FIRST = 1'b1;
  typedef enum logic {SWEEP = 1'b0, IDLE = 1'b1} initState_t;
endpackage

// File: rtl/ram_init_fsm.sv
// ram_init_fsm: walks every address once after reset or on request, then raises Ready
module ram_init_fsm
  import ram_pkg::*;
#(
  parameter int A = 9
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InitReq,
  output logic         Ready,
  output logic         SwpEnb,
  output logic [A-1:0] SwpAddr
);
  initState_t state;
  // sweep address counter; Ready registered so it rises the cycle after the last sweep write
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      state   <= SWEEP;
      SwpAddr <= '0;
      Ready   <= 1'b0;
    end else if (state == SWEEP) begin
      SwpAddr <= SwpAddr + 1'b1;
      if (&SwpAddr) begin
        state <= IDLE;
        Ready <= 1'b1;
      end
    end else if (InitReq) begin
      state   <= SWEEP;
      SwpAddr <= '0;
      Ready   <= 1'b0;
    end
  assign SwpEnb = state == SWEEP;
endmodule

// File: rtl/ram_w1rw1_init.sv
// ram_w1rw1_init: read/write + write-only RAM with collision priority, forwarding and init sweep
module ram_w1rw1_init
  import ram_pkg::*;
#(
  parameter int           A        = 9,
  parameter int           D        = 64,
  parameter bit           RD_MODE  = RD_FIRST,
  parameter bit           OUT_REG  = 1'b0,
  parameter bit           WR_WINS  = 1'b1,
  parameter logic [D-1:0] INIT_VAL = '0
) (
  input  logic         Clk,
  input  logic         Rst,
  input  logic         InitReq,
  output logic         Ready,
  input  logic         RwReq,
  input  logic         RwEnb,
  input  logic [A-1:0] RwAddr,
  input  logic [D-1:0] RwData,
  output logic [D-1:0] RwDataOut,
  output logic         RwValid,
  input  logic         WrEnb,
  input  logic [A-1:0] WrAddr,
  input  logic [D-1:0] WrData,
  output logic         RwWrColl
);
  logic         swpEnb;
  logic [A-1:0] swpAddr;
  logic         rwRd, rwWr, wrWr, sameAddr, coll, aWe, bWe, fwdHit;
  logic [A-1:0] bAddr;
  logic [D-1:0] bData, fwdData, rdRaw, fwd1, data1;
  logic         v1, has1, hit1, coll1;
  logic [D-1:0] mem [2**A];

  ram_init_fsm #(.A(A)) uInit (
    .Clk(Clk),
    .Rst(Rst),
    .InitReq(InitReq),
    .Ready(Ready),
    .SwpEnb(swpEnb),
    .SwpAddr(swpAddr)
  );

  // gate requests on Ready, resolve same-address double writes, steal the Wr port for the sweep
  always_comb begin
    rwRd     = RwReq & Ready;
    rwWr     = RwEnb & Ready;
    wrWr     = WrEnb & Ready;
    sameAddr = RwAddr == WrAddr;
    coll     = rwWr & wrWr & sameAddr;
    aWe      = rwWr & ~(coll & WR_WINS);
    bWe      = swpEnb | (wrWr & ~(coll & ~WR_WINS));
    bAddr    = swpEnb ? swpAddr : WrAddr;
    bData    = swpEnb ? INIT_VAL : WrData;
    fwdHit   = (RD_MODE == WR_FIRST) & (aWe | (bWe & sameAddr));
    fwdData  = (bWe & sameAddr) ? WrData : RwData;
  end

  // storage array with registered read; non-blocking read gives old data on a same-cycle write
  always_ff @(posedge Clk) begin
    if (aWe) mem[RwAddr] <= RwData;
    if (bWe) mem[bAddr] <= bData;
    if (rwRd) rdRaw <= mem[RwAddr];
  end

  // first read stage: valid, forwarding select and collision flag
  always_ff @(posedge Clk or posedge Rst)
    if (Rst) begin
      v1    <= 1'b0;
      has1  <= 1'b0;
      hit1  <= 1'b0;
      fwd1  <= '0;
      coll1 <= 1'b0;
    end else begin
      v1    <= rwRd;
      coll1 <= coll;
      if (rwRd) begin
        has1 <= 1'b1;
        hit1 <= fwdHit;
        fwd1 <= fwdData;
      end
    end

  assign data1    = has1 ? (hit1 ? fwd1 : rdRaw) : '0;
  assign RwWrColl = coll1;

  if (OUT_REG) begin : gOut
    logic         v2;
    logic [D-1:0] d2;
    // optional output register; keeps draining after Ready drops
    always_ff @(posedge Clk or posedge Rst)
      if (Rst) begin
        v2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        if (v1) d2 <= data1;
      end
    assign RwValid   = v2;
    assign RwDataOut = d2;
  end else begin : gNoOut
    assign RwValid   = v1;
    assign RwDataOut = data1;
  end
endmodule

// File: tb/tb_ram_w1rw1_init.sv
// tb_ram_w1rw1_init: directed checks of two configurations driven by the same stimulus
module tb_ram_w1rw1_init;
  localparam int           A  = 4;
  localparam int           D  = 16;
  localparam logic [D-1:0] IV = 16'h00A5;

  logic         Clk = 1'b0, Rst = 1'b0, InitReq = 1'b0, RwReq = 1'b0, RwEnb = 1'b0, WrEnb = 1'b0;
  logic [A-1:0] RwAddr = '0, WrAddr = '0;
  logic [D-1:0] RwData = '0, WrData = '0;
  logic         rdy0, rdy1, v0, v1, c0, c1;
  logic [D-1:0] q0, q1;
  int           errs = 0, checks = 0;

  always #5 Clk = ~Clk;

  ram_w1rw1_init #(.A(A), .D(D), .RD_MODE(1'b0), .OUT_REG(1'b0), .WR_WINS(1'b1), .INIT_VAL(IV)) dut0 (
    .Clk(Clk), .Rst(Rst), .InitReq(InitReq), .Ready(rdy0),
    .RwReq(RwReq), .RwEnb(RwEnb), .RwAddr(RwAddr), .RwData(RwData),
    .RwDataOut(q0), .RwValid(v0),
    .WrEnb(WrEnb), .WrAddr(WrAddr), .WrData(WrData), .RwWrColl(c0)
  );

  ram_w1rw1_init #(.A(A), .D(D), .RD_MODE(1'b1), .OUT_REG(1'b1), .WR_WINS(1'b0), .INIT_VAL(IV)) dut1 (
    .Clk(Clk), .Rst(Rst), .InitReq(InitReq), .Ready(rdy1),
    .RwReq(RwReq), .RwEnb(RwEnb), .RwAddr(RwAddr), .RwData(RwData),
    .RwDataOut(q1), .RwValid(v1),
    .WrEnb(WrEnb), .WrAddr(WrAddr), .WrData(WrData), .RwWrColl(c1)
  );

  task automatic tick;
    @(negedge Clk);
  endtask

  // issue one read (plus any write already set up), dut0 answers at T+1, dut1 at T+2
  task automatic do_read(input logic [A-1:0] a, input logic [D-1:0] e0, input logic [D-1:0] e1);
    RwReq = 1'b1; RwAddr = a;
    tick;
    RwReq = 1'b0; RwEnb = 1'b0; WrEnb = 1'b0;
    checks++;
    if (v0 !== 1'b1 || q0 !== e0) begin errs++; $display("FAIL rd0 @%0d: valid=%b data=%h want 1/%h", a, v0, q0, e0); end
    checks++;
    if (v1 !== 1'b0) begin errs++; $display("FAIL rd1_early @%0d: valid=%b want 0", a, v1); end
    tick;
    checks++;
    if (v1 !== 1'b1 || q1 !== e1) begin errs++; $display("FAIL rd1 @%0d: valid=%b data=%h want 1/%h", a, v1, q1, e1); end
    checks++;
    if (v0 !== 1'b0 || q0 !== e0) begin errs++; $display("FAIL rd0_hold @%0d: valid=%b data=%h want 0/%h", a, v0, q0, e0); end
  endtask

  task automatic test_reset;
    Rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({rdy0, rdy1, v0, v1, c0, c1} !== 6'b0 || q0 !== '0 || q1 !== '0) begin
      errs++; $display("FAIL reset: rdy=%b%b valid=%b%b coll=%b%b data=%h/%h want all 0", rdy0, rdy1, v0, v1, c0, c1, q0, q1);
    end
  endtask

  task automatic test_init;
    int n = 0;
    Rst = 1'b0;
    while (!rdy0 && n < 100) begin n++; tick; end
    checks++;
    if (n != 16 || rdy1 !== 1'b1) begin errs++; $display("FAIL init_len: cycles=%0d rdy1=%b want 16/1", n, rdy1); end
    for (int i = 0; i < 16; i++) do_read(i[A-1:0], IV, IV);
  endtask

  task automatic test_latency;
    RwEnb = 1'b1; RwAddr = 4'd5; RwData = 16'h1234;
    tick;
    RwEnb = 1'b0;
    do_read(4'd5, 16'h1234, 16'h1234);
  endtask

  task automatic test_rdw;
    RwEnb = 1'b1; RwAddr = 4'd3; RwData = 16'h0011;
    tick;
    RwEnb = 1'b0;
    WrEnb = 1'b1; WrAddr = 4'd3; WrData = 16'h0022;
    do_read(4'd3, 16'h0011, 16'h0022);
    do_read(4'd3, 16'h0022, 16'h0022);
    RwEnb = 1'b1; RwData = 16'h0044;
    do_read(4'd4, IV, 16'h0044);
    do_read(4'd4, 16'h0044, 16'h0044);
  endtask

  task automatic test_collision;
    RwEnb = 1'b1; RwAddr = 4'd7; RwData = 16'h00AA;
    WrEnb = 1'b1; WrAddr = 4'd7; WrData = 16'h00BB;
    tick;
    RwEnb = 1'b0; WrEnb = 1'b0;
    checks++;
    if (c0 !== 1'b1 || c1 !== 1'b1) begin errs++; $display("FAIL coll_set: coll=%b%b want 11", c0, c1); end
    tick;
    checks++;
    if (c0 !== 1'b0 || c1 !== 1'b0) begin errs++; $display("FAIL coll_clr: coll=%b%b want 00", c0, c1); end
    do_read(4'd7, 16'h00BB, 16'h00AA);
    RwEnb = 1'b1; RwData = 16'h00CC;
    WrEnb = 1'b1; WrAddr = 4'd7; WrData = 16'h00DD;
    do_read(4'd7, 16'h00BB, 16'h00CC);
    do_read(4'd7, 16'h00DD, 16'h00CC);
    RwEnb = 1'b1; RwAddr = 4'd1; RwData = 16'h0101;
    WrEnb = 1'b1; WrAddr = 4'd2; WrData = 16'h0202;
    tick;
    RwEnb = 1'b0; WrEnb = 1'b0;
    tick;
    checks++;
    if (c0 !== 1'b0 || c1 !== 1'b0) begin errs++; $display("FAIL coll_diff: coll=%b%b want 00", c0, c1); end
    do_read(4'd1, 16'h0101, 16'h0101);
    do_read(4'd2, 16'h0202, 16'h0202);
  endtask

  task automatic test_reinit;
    int n;
    RwReq = 1'b1; RwAddr = 4'd5; InitReq = 1'b1;
    tick;
    RwReq = 1'b0; InitReq = 1'b0;
    checks++;
    if (rdy0 !== 1'b0 || v0 !== 1'b1 || q0 !== 16'h1234) begin
      errs++; $display("FAIL reinit_rd0: rdy=%b valid=%b data=%h want 0/1/1234", rdy0, v0, q0);
    end
    tick;
    checks++;
    if (rdy1 !== 1'b0 || v1 !== 1'b1 || q1 !== 16'h1234) begin
      errs++; $display("FAIL reinit_drain1: rdy=%b valid=%b data=%h want 0/1/1234", rdy1, v1, q1);
    end
    InitReq = 1'b1; WrEnb = 1'b1; WrAddr = 4'd0; WrData = 16'h5555;
    tick;
    InitReq = 1'b0; WrEnb = 1'b0;
    n = 2;
    while (!rdy0 && n < 100) begin n++; tick; end
    checks++;
    if (n != 16 || rdy1 !== 1'b1) begin errs++; $display("FAIL reinit_len: cycles=%0d rdy1=%b want 16/1", n, rdy1); end
    for (int i = 0; i < 16; i++) do_read(i[A-1:0], IV, IV);
  endtask

  task automatic test_reset_mid_sweep;
    int n = 0;
    InitReq = 1'b1;
    tick;
    InitReq = 1'b0;
    for (int i = 0; i < 9; i++) tick;
    Rst = 1'b1;
    #1;
    checks++;
    if ({rdy0, rdy1, v0, v1, c0, c1} !== 6'b0 || q0 !== '0 || q1 !== '0) begin
      errs++; $display("FAIL mid_reset: rdy=%b%b valid=%b%b coll=%b%b data=%h/%h want all 0", rdy0, rdy1, v0, v1, c0, c1, q0, q1);
    end
    tick;
    Rst = 1'b0;
    while (!rdy0 && n < 100) begin n++; tick; end
    checks++;
    if (n != 16 || rdy1 !== 1'b1) begin errs++; $display("FAIL mid_reset_len: cycles=%0d rdy1=%b want 16/1", n, rdy1); end
    do_read(4'd9, IV, IV);
    do_read(4'd15, IV, IV);
  endtask

  initial begin
    test_reset;
    test_init;
    test_latency;
    test_rdw;
    test_collision;
    test_reinit;
    test_reset_mid_sweep;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
